// File: rtl/chip_cp_arb_pkg.sv
// Shared types for the chip control-plane arbiter: source encoding and the
// request record carried through the output stage.
package chip_cp_arb_pkg;

  localparam int unsigned CP_ADDR_W = 37;
  localparam int unsigned CP_DATA_W = 28;
  localparam int unsigned CP_CNT_W  = 4;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } cp_src_e;

  typedef struct packed {
    logic [CP_ADDR_W-1:0] addr;
    logic [CP_DATA_W-1:0] data;
    cp_src_e              src;
  } cp_req_t;

  // Saturating increment of the burst counter.
  function automatic logic [CP_CNT_W-1:0] sat_inc(input logic [CP_CNT_W-1:0] cnt,
                                                  input logic [CP_CNT_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + CP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/chip_cp_out_stage.sv
// Single-entry valid/ready output register. Accepts a new entry whenever it is
// empty or its current entry drains in the same cycle.
module chip_cp_out_stage
  import chip_cp_arb_pkg::*;
#(
  parameter type req_t = cp_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  req_t in_req,
  output logic load_en,
  output logic out_valid,
  output req_t out_req,
  input  logic out_ready
);

  logic valid_q, valid_d;
  req_t req_q, req_d;

  assign load_en   = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_req   = req_q;

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (load_en) begin
      valid_d = in_valid;
      if (in_valid) begin
        req_d = in_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: rtl/chip_cp_arbiter.sv
// Weighted round-robin arbiter: block_a gets up to MAX_BURST consecutive grants
// while block_b waits, then block_b gets one slot. Output is registered.
module chip_cp_arbiter
  import chip_cp_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CP_ADDR_W,
  parameter int unsigned DATA_WIDTH = CP_DATA_W,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_src
);

  localparam logic [CP_CNT_W-1:0] BurstLim = CP_CNT_W'(MAX_BURST);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    cp_src_e               src;
  } req_t;

  logic                load_en;
  logic                a_wins;
  logic                grant_a;
  logic                grant_b;
  logic [CP_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  cp_src_e             last_src_q, last_src_d;
  req_t                in_req;
  req_t                out_req;

  // A wins a tie until its burst allowance is used up; readies are held low in reset.
  always_comb begin
    a_wins  = !b_valid || (burst_cnt_q < BurstLim);
    grant_a = rst_n && load_en && a_valid && a_wins;
    grant_b = rst_n && load_en && b_valid && !(a_valid && a_wins);
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    in_req.addr = grant_b ? b_addr : a_addr;
    in_req.data = grant_b ? b_data : a_data;
    in_req.src  = grant_b ? SRC_B : SRC_A;
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    last_src_d  = last_src_q;
    if (!b_valid || grant_b) begin
      burst_cnt_d = '0;
    end else if (grant_a) begin
      burst_cnt_d = sat_inc(burst_cnt_q, BurstLim);
    end
    if (grant_a) begin
      last_src_d = SRC_A;
    end else if (grant_b) begin
      last_src_d = SRC_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
      last_src_q  <= SRC_B;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      last_src_q  <= last_src_d;
    end
  end

  chip_cp_out_stage #(
    .req_t (req_t)
  ) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (grant_a || grant_b),
    .in_req    (in_req),
    .load_en   (load_en),
    .out_valid (out_valid),
    .out_req   (out_req),
    .out_ready (out_ready)
  );

  assign out_addr = out_req.addr;
  assign out_data = out_req.data;
  // last_src equals the stored src whenever the stage holds an entry.
  assign out_src  = out_valid ? last_src_q : out_req.src;

endmodule

// File: tb/tb_chip_cp_arbiter.sv
// Directed bench for chip_cp_arbiter: stimulus queues feed both requesters,
// hand-ordered expectations go into a scoreboard drained by an output monitor.
module tb_chip_cp_arbiter;

  typedef struct packed {
    logic        src;
    logic [36:0] addr;
    logic [27:0] data;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [36:0] a_addr, b_addr, out_addr;
  logic [27:0] a_data, b_data, out_data;
  logic        out_valid, out_ready, out_src;

  item_t a_q[$];
  item_t b_q[$];
  item_t exp_q[$];

  int   n_chk;
  int   n_pass;
  logic or_val;
  logic b_en;
  logic got_a, got_b;

  chip_cp_arbiter #(
    .ADDR_WIDTH (37),
    .DATA_WIDTH (28),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic item_t mk(input logic src, input int id);
    item_t it;
    it.src  = src;
    it.addr = src ? 37'h0B_0000_0000 + 37'(id) : 37'h0A_0000_0000 + 37'(id);
    it.data = src ? 28'hB00_0000 + 28'(id) : 28'hA00_0000 + 28'(id);
    return it;
  endfunction

  // Push the hand-derived output order, e.g. "AAAAB", numbering each source from a0/b0.
  task automatic expect_pattern(input string pat, input int a0, input int b0);
    int ai = a0;
    int bi = b0;
    for (int i = 0; i < pat.len(); i++) begin
      if (pat[i] == "A") begin
        exp_q.push_back(mk(1'b0, ai));
        ai++;
      end else begin
        exp_q.push_back(mk(1'b1, bi));
        bi++;
      end
    end
  endtask

  task automatic drive_cycle();
    out_ready = or_val;
    a_valid   = (a_q.size() != 0);
    if (a_valid) begin
      a_addr = a_q[0].addr;
      a_data = a_q[0].data;
    end
    b_valid = b_en && (b_q.size() != 0);
    if (b_q.size() != 0) begin
      b_addr = b_q[0].addr;
      b_data = b_q[0].data;
    end
    #1;
    got_a = a_valid && a_ready;
    got_b = b_valid && b_ready;
    if (got_a) void'(a_q.pop_front());
    if (got_b) void'(b_q.pop_front());
  endtask

  task automatic run(input int n, input logic rdy);
    or_val = rdy;
    repeat (n) begin
      @(negedge clk);
      drive_cycle();
    end
  endtask

  task automatic drain();
    int cyc = 0;
    or_val = 1'b1;
    while (exp_q.size() != 0 && cyc < 40) begin
      @(negedge clk);
      drive_cycle();
      cyc++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Output monitor: scores each transfer and holds stalled entries to stability.
  initial begin
    item_t cur;
    item_t prev;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = {out_src, out_addr, out_data};
        if (prev_stall) begin
          chk("stall_valid_held", 128'(out_valid), 128'd1);
          chk("stall_entry_held", 128'(cur), 128'(prev));
        end
        if (out_valid && !out_ready) begin
          chk("stall_no_ready", 128'({a_ready, b_ready}), 128'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL out_unexpected: got 0x%0h expected nothing at %0t", cur, $time);
          end else begin
            chk("out_entry", 128'(cur), 128'(exp_q.pop_front()));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev       = cur;
      end
    end
  end

  initial begin
    item_t it;
    n_chk   = 0;
    n_pass  = 0;
    or_val  = 1'b1;
    b_en    = 1'b1;
    rst_n   = 1'b0;
    got_a   = 1'b0;
    got_b   = 1'b0;
    a_addr  = '0;
    a_data  = '0;
    b_addr  = '0;
    b_data  = '0;

    // 1: reset with both requesting, then A wins first
    a_q.push_back(mk(1'b0, 0));
    b_q.push_back(mk(1'b1, 0));
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_addr    = a_q[0].addr;
    a_data    = a_q[0].data;
    b_addr    = b_q[0].addr;
    b_data    = b_q[0].data;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_addr", 128'(out_addr), 128'd0);
    chk("rst_out_data", 128'(out_data), 128'd0);
    chk("rst_out_src", 128'(out_src), 128'd0);
    chk("rst_readies", 128'({a_ready, b_ready}), 128'd0);
    expect_pattern("AB", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle();
    chk("first_grant_a", 128'(got_a), 128'd1);
    chk("first_grant_not_b", 128'(got_b), 128'd0);
    drain();

    // 2: both streaming, A,A,A,A,B repeating
    for (int i = 1; i <= 8; i++) a_q.push_back(mk(1'b0, i));
    for (int i = 1; i <= 2; i++) b_q.push_back(mk(1'b1, i));
    expect_pattern("AAAABAAAAB", 1, 1);
    run(10, 1'b1);
    chk("wrr_a_consumed", 128'(a_q.size()), 128'd0);
    chk("wrr_b_consumed", 128'(b_q.size()), 128'd0);
    drain();

    // 3: backpressure for 5 cycles, then drain and reload on the same edge
    it = mk(1'b0, 20);
    it.data = 28'h0ABCDEF;
    a_q.push_back(it);
    exp_q.push_back(it);
    a_q.push_back(mk(1'b0, 21));
    b_q.push_back(mk(1'b1, 10));
    expect_pattern("AB", 21, 10);
    run(1, 1'b1);
    chk("bp_first_accept", 128'(got_a), 128'd1);
    run(5, 1'b0);
    chk("bp_no_accept", 128'({got_a, got_b}), 128'd0);
    chk("bp_data_held", 128'(out_data), 128'h0ABCDEF);
    run(1, 1'b1);
    chk("bp_reload_same_edge", 128'(got_a), 128'd1);
    drain();

    // 4: B alone, ten back-to-back
    for (int i = 0; i < 10; i++) b_q.push_back(mk(1'b1, 100 + i));
    expect_pattern("BBBBBBBBBB", 0, 100);
    run(10, 1'b1);
    chk("b_only_rate", 128'(b_q.size()), 128'd0);
    chk("b_only_cnt", 128'(dut.burst_cnt_q), 128'd0);
    drain();

    // 5: B drops after three A grants, counter clears, A gets four more
    for (int i = 30; i <= 39; i++) a_q.push_back(mk(1'b0, i));
    b_q.push_back(mk(1'b1, 40));
    expect_pattern("AAAAAAAABAA", 30, 40);
    b_en = 1'b1;
    run(3, 1'b1);
    @(posedge clk);
    #1;
    chk("burst_cnt_3", 128'(dut.burst_cnt_q), 128'd3);
    b_en = 1'b0;
    run(1, 1'b1);
    @(posedge clk);
    #1;
    chk("burst_cnt_cleared", 128'(dut.burst_cnt_q), 128'd0);
    b_en = 1'b1;
    run(4, 1'b1);
    chk("b_waits_4th", 128'(got_b), 128'd0);
    run(1, 1'b1);
    chk("b_served_5th", 128'(got_b), 128'd1);
    drain();

    // 6: reset while an entry is in the stage; no replay, A priority again
    for (int i = 50; i <= 55; i++) a_q.push_back(mk(1'b0, i));
    b_q.push_back(mk(1'b1, 60));
    expect_pattern("A", 50, 0);
    b_en = 1'b0;
    run(2, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst6_out_valid", 128'(out_valid), 128'd0);
    chk("rst6_readies", 128'({a_ready, b_ready}), 128'd0);
    chk("rst6_cnt", 128'(dut.burst_cnt_q), 128'd0);
    expect_pattern("AAAAB", 52, 60);
    @(negedge clk);
    b_en  = 1'b1;
    rst_n = 1'b1;
    drive_cycle();
    chk("rst6_first_a", 128'(got_a), 128'd1);
    run(4, 1'b1);
    chk("rst6_b_after_4", 128'(got_b), 128'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
